// File: rtl/rv_pkg.sv
// Shared constants for the unified-memory arbiter: requester indices and FSM states.
package rv_pkg;

  localparam int unsigned FETCH  = 0;
  localparam int unsigned DATA   = 1;
  localparam int unsigned LOADER = 2;
  localparam int unsigned NREQ   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rv_prio_sel.sv
// Winner selection: loader > data > fetch, with a starved fetch promoted above data.
module rv_prio_sel
  import rv_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            starve,
  output logic [NREQ-1:0] win
);

  always_comb begin
    win = '0;
    if (req[LOADER])                win[LOADER] = 1'b1;
    else if (req[FETCH] && starve)  win[FETCH]  = 1'b1;
    else if (req[DATA])             win[DATA]   = 1'b1;
    else if (req[FETCH])            win[FETCH]  = 1'b1;
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Three-requester arbiter for a single-port unified memory; one access in flight,
// reads returned on a shared rdata bus with a per-requester rvalid strobe.
module rv_mem_arb
  import rv_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          RN,
  input  logic [2:0]    req,
  output logic [2:0]    gnt,
  input  logic [AW-1:0] if_addr,
  input  logic [AW-1:0] data_addr,
  input  logic [AW-1:0] ld_addr,
  input  logic          data_we,
  input  logic [DW-1:0] data_wdata,
  input  logic [DW-1:0] ld_wdata,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : '0;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [2:0]    lat_cnt;
  logic [1:0]    rd_who;
  logic          armed;
  logic          starve;
  logic [2:0]    win;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;

  assign starve = (starve_cnt == SMAX);
  assign busy   = (state != S_IDLE);

  rv_prio_sel u_sel (
    .req    (req),
    .starve (starve),
    .win    (win)
  );

  always_comb begin
    sel_addr  = if_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (win[LOADER]) begin
      sel_addr  = ld_addr;
      sel_we    = 1'b1;
      sel_wdata = ld_wdata;
    end else if (win[DATA]) begin
      sel_addr  = data_addr;
      sel_we    = data_we;
      sel_wdata = data_wdata;
    end
  end

  // RESP spans two cycles: the first captures mem_rdata, the second presents rvalid.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state      <= S_IDLE;
      gnt        <= '0;
      rvalid     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      rd_who     <= '0;
      armed      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (!req[FETCH] || gnt[FETCH]) starve_cnt <= '0;
      else if (!starve)              starve_cnt <= starve_cnt + 1'b1;

      unique case (state)
        S_IDLE: begin
          if (armed && (|req)) begin
            state     <= S_GRANT;
            gnt       <= win;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            rd_who    <= win[1:0];
          end
        end
        S_GRANT: begin
          gnt     <= '0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          lat_cnt <= LAT_INIT;
          if (mem_we)            state <= S_IDLE;
          else if (MEM_LAT == 1) state <= S_RESP;
          else                   state <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) state   <= S_RESP;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        S_RESP: begin
          if (rvalid == '0) begin
            rdata  <= mem_rdata;
            rvalid <= rd_who;
          end else begin
            rvalid <= '0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb: directed scenarios plus randomized traffic
// checked against a transaction-level timing/priority model.
module tb_rv_mem_arb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LAT = 1;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic          rn = 1'b1;
  logic [2:0]    req = '0;
  logic [2:0]    gnt;
  logic [AW-1:0] if_addr = '0, data_addr = '0, ld_addr = '0;
  logic          data_we = 1'b0;
  logic [DW-1:0] data_wdata = '0, ld_wdata = '0;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  logic          rn3 = 1'b1;
  logic [2:0]    req3 = '0;
  logic [2:0]    gnt3;
  logic [AW-1:0] if_addr3 = '0, data_addr3 = '0, ld_addr3 = '0;
  logic          data_we3 = 1'b0;
  logic [DW-1:0] data_wdata3 = '0, ld_wdata3 = '0;
  logic [1:0]    rvalid3;
  logic [DW-1:0] rdata3;
  logic          mem_en3, mem_we3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] mem_wdata3, mem_rdata3;
  logic          busy3;

  logic [DW-1:0] mem  [0:31];
  logic [DW-1:0] mem3 [0:31];
  logic [DW-1:0] p0, p1;

  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(STARVE)) u_dut (
    .clk(clk), .RN(rn), .req(req), .gnt(gnt), .if_addr(if_addr), .data_addr(data_addr),
    .ld_addr(ld_addr), .data_we(data_we), .data_wdata(data_wdata), .ld_wdata(ld_wdata),
    .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(STARVE)) u_dut3 (
    .clk(clk), .RN(rn3), .req(req3), .gnt(gnt3), .if_addr(if_addr3), .data_addr(data_addr3),
    .ld_addr(ld_addr3), .data_we(data_we3), .data_wdata(data_wdata3), .ld_wdata(ld_wdata3),
    .rvalid(rvalid3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory devices: latency 1 and latency 3, junk on the bus when no read is due.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
  end

  always @(posedge clk) begin
    if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    p0 <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : $urandom;
    p1 <= p0;
    mem_rdata3 <= p1;
  end

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset;
    #1 rn = 1'b0; rn3 = 1'b0;
    repeat (2) tick;
    checks++; if ({gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy} !== '0) begin
      errors++; $display("FAIL reset_outs: got gnt=%b rv=%b en=%b we=%b busy=%b want all 0", gnt, rvalid, mem_en, mem_we, busy); end
    checks++; if ({gnt3, rvalid3, mem_en3, mem_we3, mem_addr3, mem_wdata3, rdata3, busy3} !== '0) begin
      errors++; $display("FAIL reset_outs3: got gnt=%b rv=%b en=%b busy=%b want all 0", gnt3, rvalid3, mem_en3, busy3); end
    req = 3'b100; ld_addr = 5'd9; ld_wdata = 32'hCAFE_0009;
    rn = 1'b1; rn3 = 1'b1;
    tick;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL first_edge_gnt: got %b want 000", gnt); end
    tick;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL second_edge_gnt: got %b want 100", gnt); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 5'd9, 32'hCAFE_0009}) begin
      errors++; $display("FAIL ld_bus: got en=%b we=%b a=%0d d=%h want 1 1 9 cafe0009", mem_en, mem_we, mem_addr, mem_wdata); end
    req = '0;
    tick;
    checks++; if (mem[9] !== 32'hCAFE_0009) begin errors++; $display("FAIL ld_write: got %h want cafe0009", mem[9]); end
    checks++; if ({busy, rvalid} !== 3'b000) begin errors++; $display("FAIL ld_no_rvalid: got busy=%b rv=%b want 0 00", busy, rvalid); end
  endtask

  task automatic test_fetch_read;
    req = 3'b001; if_addr = 5'd3;
    tick;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL fetch_gnt: got %b want 001", gnt); end
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 5'd3}) begin
      errors++; $display("FAIL fetch_bus: got en=%b we=%b a=%0d want 1 0 3", mem_en, mem_we, mem_addr); end
    req = '0;
    tick;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL fetch_early_rv: got %b want 00", rvalid); end
    tick;
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL fetch_rv: got %b want 01", rvalid); end
    checks++; if (rdata !== 32'h0220_8300) begin errors++; $display("FAIL fetch_rdata: got %h want 02208300", rdata); end
    tick;
    checks++; if ({rvalid, busy} !== 3'b000) begin errors++; $display("FAIL fetch_done: got rv=%b busy=%b want 00 0", rvalid, busy); end
    checks++; if (rdata !== 32'h0220_8300) begin errors++; $display("FAIL fetch_hold: got %h want 02208300", rdata); end
  endtask

  task automatic test_loader_vs_data;
    logic [DW-1:0] d6;
    d6 = mem[6];
    req = 3'b110; ld_addr = 5'd5; ld_wdata = 32'h1D0A_D005; data_addr = 5'd6; data_we = 1'b0;
    tick;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL lvd_first: got %b want 100", gnt); end
    checks++; if ({mem_we, mem_addr} !== {1'b1, 5'd5}) begin errors++; $display("FAIL lvd_ld_bus: got we=%b a=%0d want 1 5", mem_we, mem_addr); end
    req[2] = 1'b0;
    tick;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL lvd_gap: got %b want 000", gnt); end
    tick;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL lvd_second: got %b want 010", gnt); end
    checks++; if ({mem_we, mem_addr} !== {1'b0, 5'd6}) begin errors++; $display("FAIL lvd_data_bus: got we=%b a=%0d want 0 6", mem_we, mem_addr); end
    req[1] = 1'b0;
    repeat (2) tick;
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL lvd_rv: got %b want 10", rvalid); end
    checks++; if (rdata !== d6) begin errors++; $display("FAIL lvd_rdata: got %h want %h", rdata, d6); end
    tick;
  endtask

  task automatic test_starve;
    logic [1:0] rr;
    logic [2:0] exp;
    rr = '0;
    req = 3'b011; data_addr = 5'd10; data_we = 1'b0; if_addr = 5'd11;
    for (int k = 1; k <= 16; k++) begin
      tick;
      exp = (k == 1 || k == 9) ? 3'b010 : (k == 5 || k == 13) ? 3'b001 : 3'b000;
      checks++; if (gnt !== exp) begin errors++; $display("FAIL starve_gnt k=%0d: got %b want %b", k, gnt, exp); end
      for (int b = 0; b < 2; b++) begin
        if (gnt[b]) begin req[b] = 1'b0; rr[b] = 1'b1; end
        else if (rr[b]) begin req[b] = 1'b1; rr[b] = 1'b0; end
      end
    end
    req = '0;
  endtask

  task automatic test_random;
    localparam int N = 400;
    localparam int DRAIN = 24;
    logic [DW-1:0] mm [0:31];
    int ns, g_cyc, rv_cyc, b_end, rf, w;
    logic [2:0] g_vec, pend, jd;
    logic [1:0] rv_vec;
    logic g_we, wr;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, rv_data;
    for (int i = 0; i < 32; i++) mm[i] = mem[i];
    ns = cyc; g_cyc = -1; rv_cyc = -1; b_end = -2; rf = 0;
    pend = '0; jd = '0; req = '0;
    g_vec = '0; rv_vec = '0; g_we = 1'b0; g_addr = '0; g_wd = '0; rv_data = '0;
    for (int n = 0; n < N + DRAIN; n++) begin
      checks++; if (gnt !== ((cyc == g_cyc) ? g_vec : 3'b000)) begin
        errors++; $display("FAIL rnd_gnt c=%0d: got %b want %b", cyc, gnt, (cyc == g_cyc) ? g_vec : 3'b000); end
      checks++; if (mem_en !== (cyc == g_cyc)) begin errors++; $display("FAIL rnd_en c=%0d: got %b want %b", cyc, mem_en, cyc == g_cyc); end
      if (cyc == g_cyc) begin
        checks++; if ({mem_we, mem_addr} !== {g_we, g_addr}) begin
          errors++; $display("FAIL rnd_bus c=%0d: got we=%b a=%0d want %b %0d", cyc, mem_we, mem_addr, g_we, g_addr); end
        if (g_we) begin
          checks++; if (mem_wdata !== g_wd) begin errors++; $display("FAIL rnd_wdata c=%0d: got %h want %h", cyc, mem_wdata, g_wd); end
        end
      end
      checks++; if (rvalid !== ((cyc == rv_cyc) ? rv_vec : 2'b00)) begin
        errors++; $display("FAIL rnd_rv c=%0d: got %b want %b", cyc, rvalid, (cyc == rv_cyc) ? rv_vec : 2'b00); end
      if (cyc == rv_cyc) begin
        checks++; if (rdata !== rv_data) begin errors++; $display("FAIL rnd_rdata c=%0d: got %h want %h", cyc, rdata, rv_data); end
      end
      checks++; if (busy !== (cyc >= g_cyc && cyc <= b_end)) begin
        errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", cyc, busy, cyc >= g_cyc && cyc <= b_end); end

      for (int i = 0; i < 3; i++) begin
        if (pend[i] && gnt[i]) begin pend[i] = 1'b0; req[i] = 1'b0; jd[i] = 1'b1; end
        else if (jd[i]) jd[i] = 1'b0;
        else if (!pend[i] && n < N && $urandom_range(3) == 0) begin
          pend[i] = 1'b1; req[i] = 1'b1;
          case (i)
            0: begin if_addr = 5'($urandom); rf = cyc; end
            1: begin data_addr = 5'($urandom); data_we = 1'($urandom); data_wdata = $urandom; end
            default: begin ld_addr = 5'($urandom); ld_wdata = $urandom; end
          endcase
        end
      end

      if (cyc >= ns && req != 3'b000) begin
        if (req[2]) w = 2;
        else if (req[0] && (cyc - rf) >= STARVE) w = 0;
        else if (req[1]) w = 1;
        else w = 0;
        g_cyc = cyc + 1;
        g_vec = 3'b001 << w;
        wr = (w == 2) || (w == 1 && data_we);
        g_we = wr;
        g_addr = (w == 0) ? if_addr : (w == 1) ? data_addr : ld_addr;
        g_wd = (w == 2) ? ld_wdata : data_wdata;
        if (wr) begin
          mm[g_addr] = g_wd; ns = cyc + 2; b_end = cyc + 1;
        end else begin
          rv_cyc = cyc + LAT + 2; rv_vec = (w == 0) ? 2'b01 : 2'b10;
          rv_data = mm[g_addr]; ns = cyc + LAT + 3; b_end = cyc + LAT + 2;
        end
      end
      tick;
    end
    req = '0;
  endtask

  task automatic test_lat3;
    logic [DW-1:0] d7;
    d7 = mem3[7];
    req3 = 3'b010; data_addr3 = 5'd7; data_we3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) begin
        checks++; if (gnt3 !== 3'b010) begin errors++; $display("FAIL lat3_gnt: got %b want 010", gnt3); end
        req3 = '0;
      end
      checks++; if (rvalid3 !== ((k == 5) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL lat3_rv k=%0d: got %b want %b", k, rvalid3, (k == 5) ? 2'b10 : 2'b00); end
      if (k == 5) begin
        checks++; if (rdata3 !== d7) begin errors++; $display("FAIL lat3_rdata: got %h want %h", rdata3, d7); end
      end
      checks++; if (busy3 !== (k <= 5)) begin errors++; $display("FAIL lat3_busy k=%0d: got %b want %b", k, busy3, k <= 5); end
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d4;
    req3 = 3'b010; data_addr3 = 5'd2; data_we3 = 1'b0;
    tick;
    req3 = '0;
    tick;
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL mid_inflight: got busy=%b want 1", busy3); end
    rn3 = 1'b0;
    #1;
    checks++; if ({gnt3, rvalid3, mem_en3, mem_we3, mem_addr3, mem_wdata3, rdata3, busy3} !== '0) begin
      errors++; $display("FAIL mid_reset_outs: got gnt=%b rv=%b en=%b busy=%b rdata=%h want all 0", gnt3, rvalid3, mem_en3, busy3, rdata3); end
    tick;
    rn3 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++; if (rvalid3 !== 2'b00) begin errors++; $display("FAIL mid_no_rv k=%0d: got %b want 00", k, rvalid3); end
    end
    d4 = mem3[4];
    req3 = 3'b001; if_addr3 = 5'd4;
    tick;
    checks++; if (gnt3 !== 3'b001) begin errors++; $display("FAIL mid_next_gnt: got %b want 001", gnt3); end
    req3 = '0;
    repeat (4) tick;
    checks++; if (rvalid3 !== 2'b01) begin errors++; $display("FAIL mid_next_rv: got %b want 01", rvalid3); end
    checks++; if (rdata3 !== d4) begin errors++; $display("FAIL mid_next_rdata: got %h want %h", rdata3, d4); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      mem3[i] = $urandom;
    end
    mem[3] = 32'h0220_8300;
    test_reset;
    test_fetch_read;
    test_loader_vs_data;
    test_starve;
    test_random;
    test_lat3;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
